// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial chunk adder.
//   state_e    : control FSM states (IDLE, RUN, DONE)
//   nchunk()   : number of CHUNK-bit slices in a WIDTH-bit operand
//   idx_width(): width of the chunk index, clog2(NCHUNK) but never below 1
`timescale 1ns/1ps
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells.
//   a_i, b_i : CHUNK-bit addends
//   c_i      : carry into bit 0
//   sum_o    : CHUNK-bit sum
//   co_o     : carry out of the top bit
//   c_msb_o  : carry into the top bit (used for signed overflow)
`timescale 1ns/1ps
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             co_o,
    output logic             c_msb_o
);

    // Each stage owns its own carry scalars so the chain is not one
    // self-referencing vector.
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = c_i;
        end else begin : g_next
            assign ci = g_bit[i-1].co;
        end
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (ci),
            .s_o (sum_o[i]),
            .c_o (co)
        );
    end

    assign co_o    = g_bit[CHUNK-1].co;
    assign c_msb_o = g_bit[CHUNK-1].ci;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   a_i, b_i : addend bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
`timescale 1ns/1ps
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor processing CHUNK bits per clock, LSB chunk
// first, with one registered carry between chunks.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request an operation (accepted only while busy=0)
//   a, b       : operands, sampled on the accepting edge
//   cin        : carry-in (add) / borrow-in (sub)
//   sub        : 0 = a+b+cin, 1 = a-b-cin
//   busy       : chunks being processed
//   done       : one-cycle pulse after a result is committed
//   sum        : registered result, changes only on commit
//   cout       : carry out of MSB (sub mode: 1 = no borrow)
//   oflo       : two's-complement overflow
`timescale 1ns/1ps
module serial_chunk_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             oflo
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = idx_width(WIDTH, CHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               oflo_q, oflo_d;

    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_co;
    logic               chunk_cmsb;
    logic               accept;
    logic               last;

    // Operand registers shift right, so the active chunk is always bits [CHUNK-1:0].
    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a_i     (a_q[CHUNK-1:0]),
        .b_i     (b_q[CHUNK-1:0]),
        .c_i     (carry_q),
        .sum_o   (chunk_sum),
        .co_o    (chunk_co),
        .c_msb_o (chunk_cmsb)
    );

    // DONE counts as idle, which is what allows back-to-back accepts.
    assign accept = start && (state_q != RUN);
    assign last   = (state_q == RUN) && (idx_q == IDX_W'(NCHUNK - 1));

    // NOTE: every signal written in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        oflo_d  = oflo_q;
        if (accept) begin
            // Subtraction is A + ~B + (cin ^ sub); cin then acts as a borrow.
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = cin ^ sub;
            idx_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            carry_d = chunk_co;
            idx_d   = idx_q + IDX_W'(1);
            // New chunk enters at the top; after NCHUNK shifts it is aligned.
            part_d  = (part_q >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
            if (last) begin
                sum_d  = part_d;
                cout_d = chunk_co;
                oflo_d = chunk_cmsb ^ chunk_co;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the datapath registers are reset along with the FSM so an aborted
    // operation leaves no stale partial state and simulation never sees X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            oflo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            oflo_q  <= oflo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign oflo = oflo_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Scoreboard bench: an 8/4 instance for directed scenarios plus 32-bit
// instances with CHUNK = 1, 8, 32 for a random sweep against a model.
`timescale 1ns/1ps
module tb_serial_chunk_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        oflo;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_w_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_done8 = 0;
    bit   sweep_done [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural reference using plain integer arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb);
        exp_t   e;
        longint ua, ub, cl, sa, sbv, full, sres, half;
        ua   = longint'(a);
        ub   = longint'(b);
        cl   = ci ? 64'sd1 : 64'sd0;
        half = 64'sd1 <<< (w - 1);
        sa   = a[w-1] ? ua - 2 * half : ua;
        sbv  = b[w-1] ? ub - 2 * half : ub;
        if (!sb) begin
            full   = ua + ub + cl;
            sres   = sa + sbv + cl;
            e.cout = (full >= 2 * half);
        end else begin
            full   = ua - ub - cl;
            sres   = sa - sbv - cl;
            e.cout = (ua >= ub + cl);
        end
        e.sum  = 32'(full & (2 * half - 1));
        e.oflo = (sres >= half) || (sres < -half);
        e.acc  = 0;
        return e;
    endfunction

    // ---------------- 8-bit / 4-bit-chunk instance ----------------
    logic       d_start, d_cin, d_sub, d_busy, d_done, d_cout, d_oflo;
    logic [7:0] d_a, d_b, d_sum;
    exp_t       q8[$];

    serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (d_start),
        .a     (d_a),
        .b     (d_b),
        .cin   (d_cin),
        .sub   (d_sub),
        .busy  (d_busy),
        .done  (d_done),
        .sum   (d_sum),
        .cout  (d_cout),
        .oflo  (d_oflo)
    );

    always @(negedge clk) begin : mon8
        exp_t e;
        if (d_done === 1'b1) begin
            n_done8++;
            if (q8.size() == 0) begin
                check("done8_spurious", 1, 0);
            end else begin
                e = q8.pop_front();
                check("sum8", d_sum, e.sum);
                check("cout8", d_cout, e.cout);
                check("oflo8", d_oflo, e.oflo);
                check("lat8", cyc - e.acc, 2);
            end
        end
    end

    // Drives one request from idle; returns #1 after the accepting edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic sb, input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        @(posedge clk); #1;
        d_a = a; d_b = b; d_cin = ci; d_sub = sb; d_start = 1'b1;
        @(posedge clk); #1;
        d_start = 1'b0;
        e.sum = 32'(es); e.cout = ec; e.oflo = eo; e.acc = cyc;
        q8.push_back(e);
    endtask

    task automatic wait8();
        int t;
        t = 0;
        while (q8.size() != 0 && t < 12) begin
            @(posedge clk);
            t++;
        end
        if (q8.size() != 0) begin
            check("timeout8", q8.size(), 0);
            q8.delete();
        end
        @(posedge clk);
    endtask

    // ---------------- 32-bit sweep instances ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int CH = (g == 0) ? 1 : (g == 1) ? 8 : 32;
        localparam int NC = 32 / CH;
        logic        start, cin, sub, busy, done, cout, oflo;
        logic [31:0] a, b, sum;
        exp_t        q[$];

        serial_chunk_adder #(.WIDTH(32), .CHUNK(CH)) u_dut (
            .clk   (clk),
            .rst_n (rst_w_n),
            .start (start),
            .a     (a),
            .b     (b),
            .cin   (cin),
            .sub   (sub),
            .busy  (busy),
            .done  (done),
            .sum   (sum),
            .cout  (cout),
            .oflo  (oflo)
        );

        always @(negedge clk) begin : mon
            exp_t e;
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    check($sformatf("done_spurious_c%0d", CH), 1, 0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("sum_c%0d", CH), sum, e.sum);
                    check($sformatf("cout_c%0d", CH), cout, e.cout);
                    check($sformatf("oflo_c%0d", CH), oflo, e.oflo);
                    check($sformatf("lat_c%0d", CH), cyc - e.acc, NC);
                end
            end
        end

        initial begin : drive
            exp_t e;
            int   t;
            start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
            sweep_done[g] = 1'b0;
            wait (rst_w_n === 1'b1);
            repeat (2) @(posedge clk);
            for (int n = 0; n < 1000; n++) begin
                #1;
                a = $urandom(); b = $urandom();
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                e = model(32, a, b, cin, sub);
                e.acc = cyc;
                q.push_back(e);
                t = 0;
                while (q.size() != 0 && t < NC + 4) begin
                    @(posedge clk);
                    t++;
                end
                if (q.size() != 0) begin
                    check($sformatf("timeout_c%0d", CH), q.size(), 0);
                    q.delete();
                end
            end
            sweep_done[g] = 1'b1;
        end
    end

    // ---------------- directed scenarios ----------------
    logic [7:0] ha [3] = '{8'h11, 8'hF0, 8'h80};
    logic [7:0] hb [3] = '{8'h22, 8'h20, 8'h01};
    logic       hc [3] = '{1'b1, 1'b0, 1'b0};
    logic       hs [3] = '{1'b0, 1'b1, 1'b0};

    initial begin : main
        exp_t       e;
        logic [7:0] prev;
        int         d0;
        int         t;

        d_start = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0;
        rst_n = 1'b0; rst_w_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", d_busy, 0);
        check("rst_done", d_done, 0);
        check("rst_sum", d_sum, 0);
        check("rst_cout", d_cout, 0);
        check("rst_oflo", d_oflo, 0);
        @(negedge clk);
        rst_n = 1'b1; rst_w_n = 1'b1;

        // Add overflow, add wrap, subtract.
        issue8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1); wait8();
        issue8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); wait8();
        issue8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0); wait8();
        issue8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0); wait8();
        issue8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1); wait8();

        // start pulsed while busy with different operands must be ignored.
        d0 = n_done8;
        issue8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
        d_a = 8'hAA; d_b = 8'h55; d_sub = 1'b1; d_start = 1'b1;
        check("busy_run", d_busy, 1);
        @(posedge clk); #1;
        d_start = 1'b0; d_sub = 1'b0;
        wait8();
        repeat (3) @(posedge clk);
        check("one_done", n_done8 - d0, 1);

        // start held high: accepts every 3 cycles, sum holds during RUN.
        prev = 8'h46;
        @(posedge clk); #1;
        d_a = ha[0]; d_b = hb[0]; d_cin = hc[0]; d_sub = hs[0]; d_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            e = model(8, 32'(ha[i]), 32'(hb[i]), hc[i], hs[i]);
            e.acc = cyc;
            q8.push_back(e);
            check("hold_sum_r0", d_sum, prev);
            if (i < 2) begin
                d_a = ha[i+1]; d_b = hb[i+1]; d_cin = hc[i+1]; d_sub = hs[i+1];
            end else begin
                d_start = 1'b0;
            end
            @(posedge clk); #1;
            check("hold_sum_r1", d_sum, prev);
            prev = e.sum[7:0];
            @(posedge clk);
        end
        wait8();

        // Asynchronous reset after the first chunk aborts the operation.
        @(posedge clk); #1;
        d_a = 8'h0F; d_b = 8'h0F; d_cin = 1'b0; d_sub = 1'b0; d_start = 1'b1;
        @(posedge clk); #1;
        d_start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", d_busy, 0);
        check("abort_done", d_done, 0);
        check("abort_sum", d_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        issue8(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
        wait8();

        t = 0;
        while (!(sweep_done[0] && sweep_done[1] && sweep_done[2]) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        check("sweep_finished", (sweep_done[0] && sweep_done[1] && sweep_done[2]), 1);
        check("q8_empty", q8.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
